// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios II PIO slaves: register map and edge-capture modes.
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Per-bit edge detection for the selected capture mode; unknown modes capture nothing.
    function automatic logic [31:0] edge_sel(input int mode, input logic [31:0] cur,
                                             input logic [31:0] prv);
        logic [31:0] res;
        case (mode)
            EDGE_RISE: res = cur & ~prv;
            EDGE_FALL: res = ~cur & prv;
            EDGE_ANY:  res = cur ^ prv;
            default:   res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/nios_pio_debounce_bit.sv
// Single-bit debouncer: a level change is accepted only after DEBOUNCE_CYCLES
// consecutive cycles of disagreement with the current stable value.
module nios_pio_debounce_bit
    import nios_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sync,
    output logic o_stable
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_stable;
    logic [CW-1:0] r_cnt;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (i_sync == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == LAST) begin
            r_stable <= i_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO with synchroniser, optional debouncer, edge capture
// (write-1-to-clear), interrupt mask and level-sensitive IRQ.
module nios_pio_in_edge
    import nios_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;

    logic [WIDTH-1:0] w_stable;
    logic [31:0]      w_edge_all;
    logic [WIDTH-1:0] w_edge;
    logic             w_wr;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd;
    logic             w_unused;

    // Two-flop synchroniser plus previous-stable history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
            r_prev  <= w_stable;
        end
    end

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_db
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                nios_pio_debounce_bit #(
                    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
                ) u_db (
                    .clk      (clk),
                    .reset    (reset),
                    .i_sync   (r_sync2[i]),
                    .o_stable (w_stable[i])
                );
            end
        end else begin : g_nodb
            assign w_stable = r_sync2;
        end
    endgenerate

    assign w_edge_all = edge_sel(EDGE_TYPE, 32'(w_stable), 32'(r_prev));
    assign w_edge     = w_edge_all[WIDTH-1:0];
    assign w_wr       = chipselect & ~write_n;
    assign w_clr      = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
    assign w_unused   = ^{writedata, w_edge_all};

    // Interrupt mask; bits of writedata above WIDTH are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr && (address == ADDR_IRQMASK)) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end else begin
            r_irqmask <= r_irqmask;
        end
    end

    // Edge capture: a new edge outranks a same-cycle clear of that bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        w_rd = 32'd0;
        case (address)
            ADDR_DATA:    w_rd[WIDTH-1:0] = w_stable;
            ADDR_IRQMASK: w_rd[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rd[WIDTH-1:0] = r_edgecap;
            default:      w_rd = 32'd0;
        endcase
    end

    // Registered read data, refreshed every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 32'd0;
        end else begin
            readdata <= w_rd;
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Scoreboard bench for nios_pio_in_edge: four instances (rise, fall, any, debounced)
// share the bus; stimulus queues expectations, a monitor compares one cycle later.
module tb_nios_pio_in_edge;
    import nios_pio_pkg::*;

    typedef struct {
        int          inst;
        bit          crd;
        logic [31:0] erd;
        bit          cirq;
        logic        eirq;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic [3:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_p [4];
    logic [31:0] rdata [4];
    logic [3:0]  irq_v;

    exp_t sb_q[$];
    exp_t mon_e;
    logic rd_issue = 1'b0;
    logic issue_d  = 1'b0;
    int   n_vec    = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    nios_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(EDGE_RISE), .DEBOUNCE_CYCLES(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
        .writedata(writedata), .in_port(in_p[0]), .readdata(rdata[0]), .irq(irq_v[0]));
    nios_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(EDGE_FALL), .DEBOUNCE_CYCLES(0)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
        .writedata(writedata), .in_port(in_p[1]), .readdata(rdata[1]), .irq(irq_v[1]));
    nios_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(EDGE_ANY), .DEBOUNCE_CYCLES(0)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
        .writedata(writedata), .in_port(in_p[2]), .readdata(rdata[2]), .irq(irq_v[2]));
    nios_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(EDGE_RISE), .DEBOUNCE_CYCLES(8)) u_deb (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write_n(write_n),
        .writedata(writedata), .in_port(in_p[3]), .readdata(rdata[3]), .irq(irq_v[3]));

    // Marks the edge on which a queued expectation becomes observable.
    always @(posedge clk) issue_d <= rd_issue;

    // Monitor: pop the oldest expectation and compare against the DUT outputs.
    always @(negedge clk) begin
        if (issue_d) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty: got no expectation, required one queued");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.crd) begin
                    n_vec++;
                    if (rdata[mon_e.inst] !== mon_e.erd) begin
                        n_err++;
                        $display("FAIL %s readdata[u%0d]: got %h expected %h",
                                 mon_e.name, mon_e.inst, rdata[mon_e.inst], mon_e.erd);
                    end
                end
                if (mon_e.cirq) begin
                    n_vec++;
                    if (irq_v[mon_e.inst] !== mon_e.eirq) begin
                        n_err++;
                        $display("FAIL %s irq[u%0d]: got %b expected %b",
                                 mon_e.name, mon_e.inst, irq_v[mon_e.inst], mon_e.eirq);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input exp_t e);
        sb_q.push_back(e);
        rd_issue = 1'b1;
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic rdi(input int inst, input logic [1:0] a, input bit crd, input logic [31:0] erd,
                       input bit cirq, input logic eirq, input string nm);
        exp_t e;
        e.inst = inst; e.crd = crd; e.erd = erd; e.cirq = cirq; e.eirq = eirq; e.name = nm;
        address = a;
        issue(e);
    endtask

    task automatic rd(input int inst, input logic [1:0] a, input logic [31:0] ev, input string nm);
        rdi(inst, a, 1'b1, ev, 1'b0, 1'b0, nm);
    endtask

    task automatic chk_irq(input int inst, input logic ev, input string nm);
        rdi(inst, ADDR_DATA, 1'b0, 32'd0, 1'b1, ev, nm);
    endtask

    task automatic wr(input int inst, input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        cs[inst]   = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        cs         = 4'h0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; cs = 4'h0; write_n = 1'b1; writedata = 32'd0;
        for (int i = 0; i < 4; i++) in_p[i] = 4'h0;
        tick(3);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) rdi(0, 2'(a), 1'b1, 32'd0, 1'b1, 1'b0, "por_zero");

        // Rising capture with mask, IRQ latency and write-1-to-clear.
        wr(0, ADDR_IRQMASK, 32'h2);
        in_p[0] = 4'h2;
        chk_irq(0, 1'b0, "rise_irq_k");
        chk_irq(0, 1'b0, "rise_irq_k1");
        chk_irq(0, 1'b1, "rise_irq_k2");
        rd(0, ADDR_EDGECAP, 32'h2, "rise_edgecap");
        rd(0, ADDR_DATA, 32'h2, "rise_data");
        wr(0, ADDR_EDGECAP, 32'h2);
        chk_irq(0, 1'b0, "clr_irq");
        rd(0, ADDR_EDGECAP, 32'h0, "clr_edgecap");
        in_p[0] = 4'h0;
        tick(4);
        rd(0, ADDR_EDGECAP, 32'h0, "rise_ignores_fall");
        in_p[0] = 4'h1;
        tick(3);
        rdi(0, ADDR_EDGECAP, 1'b1, 32'h1, 1'b1, 1'b0, "unmasked_no_irq");
        wr(0, ADDR_IRQMASK, 32'h1);
        chk_irq(0, 1'b1, "mask_enable");
        wr(0, ADDR_RSVD, 32'hFFFF_FFFF);
        rd(0, ADDR_RSVD, 32'h0, "rsvd_reads_zero");
        wr(0, ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd(0, ADDR_IRQMASK, 32'hF, "mask_upper_dropped");

        // Falling capture.
        in_p[1] = 4'hF;
        tick(4);
        rd(1, ADDR_EDGECAP, 32'h0, "fall_ignores_rise");
        wr(1, ADDR_IRQMASK, 32'hF);
        in_p[1] = 4'h7;
        tick(3);
        rdi(1, ADDR_EDGECAP, 1'b1, 32'h8, 1'b1, 1'b1, "fall_cap");
        wr(1, ADDR_EDGECAP, 32'h8);
        in_p[1] = 4'hF;
        tick(4);
        rdi(1, ADDR_EDGECAP, 1'b1, 32'h0, 1'b1, 1'b0, "fall_rise_none");
        rd(1, ADDR_DATA, 32'hF, "fall_data");

        // Any-edge capture; clear collides with a new edge on the same bit.
        in_p[2] = 4'h2;
        tick(3);
        rd(2, ADDR_EDGECAP, 32'h2, "any_rise");
        in_p[2] = 4'h0;
        tick(2);
        wr(2, ADDR_EDGECAP, 32'h2);
        rd(2, ADDR_EDGECAP, 32'h2, "set_wins_clear");
        wr(2, ADDR_EDGECAP, 32'h2);
        rd(2, ADDR_EDGECAP, 32'h0, "any_clear");

        // Debounced instance: short glitch rejected, long level accepted at k+9.
        wr(3, ADDR_IRQMASK, 32'h1);
        in_p[3] = 4'h1;
        tick(5);
        in_p[3] = 4'h0;
        tick(12);
        rdi(3, ADDR_DATA, 1'b1, 32'h0, 1'b1, 1'b0, "glitch_data");
        rd(3, ADDR_EDGECAP, 32'h0, "glitch_cap");
        in_p[3] = 4'h1;
        tick(9);
        rdi(3, ADDR_DATA, 1'b1, 32'h0, 1'b1, 1'b0, "db_edge_k9");
        rdi(3, ADDR_DATA, 1'b1, 32'h1, 1'b1, 1'b1, "db_edge_k10");
        tick(9);
        in_p[3] = 4'h0;
        rd(3, ADDR_EDGECAP, 32'h1, "db_cap");

        // Mid-run reset pulse with all inputs low: everything reads zero.
        for (int i = 0; i < 4; i++) in_p[i] = 4'h0;
        tick(12);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int a = 0; a < 4; a++)
                rdi(i, 2'(a), 1'b1, 32'd0, 1'b1, 1'b0, "midrun_reset");

        // Reset during debounce progress; input already high when reset releases.
        in_p[0] = 4'h1;
        in_p[3] = 4'h1;
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(8);
        rd(3, ADDR_DATA, 32'h0, "db_rst_k8");
        rd(3, ADDR_DATA, 32'h0, "db_rst_k9");
        rd(3, ADDR_DATA, 32'h1, "db_rst_k10");
        rd(0, ADDR_EDGECAP, 32'h1, "release_rise_cap");
        rd(0, ADDR_DATA, 32'h1, "release_rise_data");

        tick(3);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nios_pio_in_edge.md
# nios_pio_in_edge

Parametrised Avalon-MM input PIO slave for the Nios II system: samples a WIDTH-bit external input bus (buttons, switches) through a two-flop synchroniser and optional per-bit debouncer, and exposes the level value. It also provides an edge-capture register with write-1-to-clear and an interrupt mask, driving a level-sensitive IRQ to the processor. It sits on the system interconnect alongside the other PIO slaves and replaces plain level-only input ports where interrupt-driven button handling is needed.

## Interface
- WIDTH, 4, input bus width; legal 1..32.
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a level change is accepted; 0 bypasses the debouncer.

- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word address of register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request, active-high.

## Operation
- Register map: addr 0 DATA (RO, debounced level, zero-extended); addr 1 reserved (reads 0, writes ignored); addr 2 IRQMASK (RW, WIDTH bits); addr 3 EDGECAP (RO bits, write 1 clears).
- Write accepted when chipselect=1 and write_n=0; writes to addr 0/1 ignored; upper writedata bits above WIDTH ignored.
- Synchroniser: sync1 <= in_port, sync2 <= sync1.
- Debouncer per bit (DEBOUNCE_CYCLES>0): holds stable bit and counter of width clog2(DEBOUNCE_CYCLES+1). sync2==stable -> counter cleared. sync2!=stable -> counter increments; on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, stable <= sync2 and counter cleared. Glitches shorter than DEBOUNCE_CYCLES cycles never reach stable. DEBOUNCE_CYCLES=0: stable = sync2 (registered pass-through not added).
- Edge detect: prev <= stable each cycle. rise = stable & ~prev, fall = ~stable & prev; selected per EDGE_TYPE.
- EDGECAP bit: set on detected edge; cleared by write with writedata bit =1 at addr 3. Same-cycle set and clear on one bit: set wins.
- irq = |(EDGECAP & IRQMASK), combinational from registers.
- readdata updates every cycle with mux of addressed register (chipselect not required, reads side-effect free).

## Timing
- Reset: sync1, sync2, stable, prev, counters, IRQMASK, EDGECAP, readdata all 0; irq 0. Reset mid-debounce discards counter progress.
- Read latency 1: address at edge k -> readdata valid after edge k.
- DEBOUNCE_CYCLES=0: in_port change sampled at edge k -> sync2 at k+1 -> EDGECAP set and irq high after edge k+2 (if masked in) -> DATA reflects new value to a read issued at k+2.
- DEBOUNCE_CYCLES=N>0: stable updates at edge k+1+N; EDGECAP/irq after edge k+2+N.
- Input high when reset releases: treated as 0->1 transition; rising edge captured per the latencies above.
- IRQMASK write takes effect on irq the cycle after the write edge; EDGECAP clear likewise.

## Structure
- Shared package nios_pio_pkg: register address constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP), EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- One sub-module: nios_pio_debounce_bit (sync2 in, stable out, DEBOUNCE_CYCLES parameter), generated WIDTH times; top holds synchroniser, edge logic, registers, read mux.

## Test plan
- Reset with in_port=4'h0, pulse reset mid-run -> all reads 0, irq 0 for every address.
- WIDTH=4, EDGE_TYPE=0, DEBOUNCE=0: IRQMASK=4'h2, in_port 0->4'h2 -> EDGECAP=4'h2, irq high 3 edges after change; write 4'h2 to addr 3 -> EDGECAP=0, irq low next cycle.
- EDGE_TYPE=1: in_port 4'hF->4'h7 -> EDGECAP=4'h8; rising 4'h7->4'hF sets nothing.
- DEBOUNCE_CYCLES=8: 5-cycle pulse on bit0 -> DATA stays 0, EDGECAP 0; 20-cycle high -> DATA=1 at edge k+9, EDGECAP bit0 at k+10.
- EDGE_TYPE=2: clear EDGECAP bit1 on same cycle a new edge on bit1 is detected -> bit1 remains 1.
- Read addr 1 -> 0; write 32'hFFFF_FFFF to addr 2 -> IRQMASK reads 4'hF.
